// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and stall controller for the five-stage RISC-V pipeline.
// Watches decode, the DEC_ALU stage register, the ALU branch outcome and the
// data-cache handshake. Drives hold/bubble/flush controls for PC, IF/DEC,
// DEC_ALU and ALU_MEM. Also keeps saturating stall/flush counters and a
// sticky memory-timeout flag.
//
// Control outputs are purely combinational (zero latency) and are forced
// low while rst_n is asserted. Counters and the timeout flag are registered.

module pipe_hazard_ctrl #(
  parameter int LOAD_USE_STALL = 1,    // bubble cycles per load-use hazard, 1..7
  parameter int MEM_TIMEOUT    = 255,  // memory-wait cycles before timeout, 1..1023
  parameter int CNT_W          = 16    // performance counter width
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             i_decValid,
  input  logic [4:0]       i_decRs1Addr,
  input  logic [4:0]       i_decRs2Addr,
  input  logic             i_decRs1Use,
  input  logic             i_decRs2Use,

  input  logic             i_exValid,
  input  logic             i_exWriteEnable,
  input  logic             i_exDataCacheReadEnable,
  input  logic [4:0]       i_exWriteBackAddr,

  input  logic             i_branchTaken,
  input  logic             i_memReq,
  input  logic             i_memReady,

  output logic             o_pcHold,
  output logic             o_ifDecHold,
  output logic             o_ifDecFlush,
  output logic             o_decAluHold,
  output logic             o_decAluBubble,
  output logic             o_aluMemHold,
  output logic             o_memTimeout,
  output logic [CNT_W-1:0] o_stallCycles,
  output logic [CNT_W-1:0] o_flushCount
);

  // Remaining-cycle reload value once the detection cycle has been spent.
  localparam logic [2:0] STALL_RELOAD  = 3'(LOAD_USE_STALL - 1);
  localparam logic [9:0] TIMEOUT_LIMIT = 10'(MEM_TIMEOUT);
  localparam logic [9:0] WAIT_MAX      = 10'h3FF;

  typedef enum logic [0:0] {
    ST_RUN        = 1'b0,
    ST_LOAD_STALL = 1'b1
  } state_t;

  // Registered state
  state_t           r_state;
  logic [2:0]       r_remaining;
  logic [9:0]       r_waitCnt;
  logic             r_memTimeout;
  logic [CNT_W-1:0] r_stallCycles;
  logic [CNT_W-1:0] r_flushCount;

  // Combinational decode of events and next state
  state_t           w_nextState;
  logic [2:0]       w_nextRemaining;
  logic             w_freeze;
  logic             w_branch;
  logic             w_rs1Match;
  logic             w_rs2Match;
  logic             w_loadUse;
  logic [9:0]       w_waitNext;

  // Ungated control values; rst_n gating is applied at the ports
  logic             w_pcHold;
  logic             w_ifDecHold;
  logic             w_ifDecFlush;
  logic             w_decAluHold;
  logic             w_decAluBubble;
  logic             w_aluMemHold;

  // Event detection: cache stall, taken branch and load-use dependency.
  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  always_comb begin
    w_freeze   = i_memReq && !i_memReady;
    w_branch   = i_exValid && i_branchTaken;
    w_rs1Match = i_decRs1Use && (i_decRs1Addr == i_exWriteBackAddr);
    w_rs2Match = i_decRs2Use && (i_decRs2Addr == i_exWriteBackAddr);
    w_loadUse  = i_exValid && i_exDataCacheReadEnable && i_exWriteEnable &&
                 (i_exWriteBackAddr != 5'd0) && i_decValid &&
                 (w_rs1Match || w_rs2Match);
    w_waitNext = (r_waitCnt == WAIT_MAX) ? r_waitCnt : (r_waitCnt + 10'd1);
  end

  // Prioritised control generation and next-state logic:
  // freeze > branch > load-use detection (RUN) > LOAD_STALL countdown.
  always_comb begin
    w_nextState     = r_state;
    w_nextRemaining = r_remaining;
    w_pcHold        = 1'b0;
    w_ifDecHold     = 1'b0;
    w_ifDecFlush    = 1'b0;
    w_decAluHold    = 1'b0;
    w_decAluBubble  = 1'b0;
    w_aluMemHold    = 1'b0;

    if (w_freeze) begin
      w_pcHold     = 1'b1;
      w_ifDecHold  = 1'b1;
      w_decAluHold = 1'b1;
      w_aluMemHold = 1'b1;
    end else if (w_branch) begin
      w_ifDecFlush    = 1'b1;
      w_decAluBubble  = 1'b1;
      w_nextState     = ST_RUN;
      w_nextRemaining = 3'd0;
    end else if ((r_state == ST_RUN) && w_loadUse) begin
      w_pcHold       = 1'b1;
      w_ifDecHold    = 1'b1;
      w_decAluBubble = 1'b1;
      if (LOAD_USE_STALL > 1) begin
        w_nextState     = ST_LOAD_STALL;
        w_nextRemaining = STALL_RELOAD;
      end
    end else if (r_state == ST_LOAD_STALL) begin
      w_pcHold        = 1'b1;
      w_ifDecHold     = 1'b1;
      w_decAluBubble  = 1'b1;
      w_nextRemaining = r_remaining - 3'd1;
      if (r_remaining <= 3'd1) begin
        w_nextState     = ST_RUN;
        w_nextRemaining = 3'd0;
      end
    end
  end

  // FSM state and remaining-cycle register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_remaining <= 3'd0;
    end else begin
      r_state     <= w_nextState;
      r_remaining <= w_nextRemaining;
    end
  end

  // Memory wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt    <= 10'd0;
      r_memTimeout <= 1'b0;
    end else begin
      if (w_freeze) begin
        r_waitCnt <= w_waitNext;
        if (w_waitNext >= TIMEOUT_LIMIT) begin
          r_memTimeout <= 1'b1;
        end
      end else begin
        r_waitCnt <= 10'd0;
      end
    end
  end

  // Saturating performance counters: stalled cycles and branch flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stallCycles <= '0;
      r_flushCount  <= '0;
    end else begin
      if (w_pcHold && (r_stallCycles != '1)) begin
        r_stallCycles <= r_stallCycles + CNT_W'(1);
      end
      if (!w_freeze && w_branch && (r_flushCount != '1)) begin
        r_flushCount <= r_flushCount + CNT_W'(1);
      end
    end
  end

  assign o_pcHold       = rst_n & w_pcHold;
  assign o_ifDecHold    = rst_n & w_ifDecHold;
  assign o_ifDecFlush   = rst_n & w_ifDecFlush;
  assign o_decAluHold   = rst_n & w_decAluHold;
  assign o_decAluBubble = rst_n & w_decAluBubble;
  assign o_aluMemHold   = rst_n & w_aluMemHold;
  assign o_memTimeout   = r_memTimeout;
  assign o_stallCycles  = r_stallCycles;
  assign o_flushCount   = r_flushCount;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the five-stage RISC-V pipeline. It watches the instruction in decode, the instruction held in the DEC_ALU stage register, the ALU branch outcome and the data-cache handshake in the ALU_MEM stage. From these it drives hold, bubble and flush controls for the PC, IF/DEC, DEC_ALU and ALU_MEM registers. It also keeps saturating stall and flush performance counters and a sticky memory-timeout flag.

## Interface
Parameters:
- LOAD_USE_STALL, 1: bubble cycles inserted per load-use hazard, legal range 1..7.
- MEM_TIMEOUT, 255: consecutive memory-wait cycles before memTimeout sets, 1..1023.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- decValid  in  1  decode stage holds a real instruction.
- decRs1Addr, decRs2Addr  in  5 each  source register addresses in decode.
- decRs1Use, decRs2Use  in  1 each  source actually read.
- exValid  in  1  DEC_ALU register holds a real instruction.
- exWriteEnable  in  1  register write enable held in DEC_ALU.
- exDataCacheReadEnable  in  1  DEC_ALU instruction is a load.
- exWriteBackAddr  in  5  destination address held in DEC_ALU.
- branchTaken  in  1  ALU resolves a taken branch or jump this cycle.
- memReq  in  1  ALU_MEM stage issues a cache access.
- memReady  in  1  cache completes the access this cycle.
- pcHold  out  1  PC keeps its value.
- ifDecHold  out  1  IF/DEC register keeps its value.
- ifDecFlush  out  1  IF/DEC loads a NOP (valid=0).
- decAluHold  out  1  DEC_ALU register keeps its value.
- decAluBubble  out  1  DEC_ALU loads a NOP: valid, writeEnable and both cache enables are 0.
- aluMemHold  out  1  ALU_MEM register keeps its value.
- memTimeout  out  1  sticky error flag.
- stallCycles  out  CNT_W  saturating count of cycles with pcHold=1.
- flushCount  out  CNT_W  saturating count of taken-branch flushes.

## Operation
- Registered state:
  - FSM with states RUN and LOAD_STALL.
  - remaining counter, 3 bits.
  - waitCnt, 10 bits.
  - memTimeout, stallCycles, flushCount.
- All hold, bubble and flush outputs are combinational from the current state and inputs. Priority, highest first:
  1. **Freeze** (memReq && !memReady): pcHold, ifDecHold, decAluHold and aluMemHold are all 1. Bubble and flush are 0. The FSM, remaining and the flush counter do not change. waitCnt increments, saturating at 1023. Every other condition is ignored this cycle.
  2. **Branch** (exValid && branchTaken): ifDecFlush=1 and decAluBubble=1. All holds are 0, so the PC takes the redirect. flushCount increments. If the FSM is in LOAD_STALL it goes to RUN.
  3. **Load-use** (RUN only): the hazard is exValid && exDataCacheReadEnable && exWriteEnable && exWriteBackAddr!=0 && decValid, and a used source register matches exWriteBackAddr. Response: pcHold=1, ifDecHold=1, decAluBubble=1. If LOAD_USE_STALL>1, go to LOAD_STALL with remaining=LOAD_USE_STALL-1.
  4. **LOAD_STALL**: pcHold=1, ifDecHold=1, decAluBubble=1. remaining decrements each cycle. When remaining==1, the FSM goes to RUN at the next edge.
  5. **Otherwise**: all controls are 0.
- A register address of x0 never creates a hazard.
- waitCnt clears on any cycle without a freeze.
- memTimeout sets at the edge where waitCnt reaches MEM_TIMEOUT. It clears only on reset.
- stallCycles increments on every cycle with pcHold=1, including freeze cycles.
- Both counters saturate at 2^CNT_W-1.

## Timing
- Reset (rst_n=0, asynchronous): FSM=RUN, remaining=0, waitCnt=0, memTimeout=0, stallCycles=0, flushCount=0.
  - While rst_n is low, every hold, bubble and flush output is forced to 0 regardless of inputs.
  - Reset asserted mid-stall aborts the stall. No state survives reset.
- Control latency is zero: controls are valid in the same cycle as the causing inputs and act at the next rising edge.
- A load-use hazard costs exactly LOAD_USE_STALL cycles of pcHold=1, plus any freeze cycles that interleave.
- A branch costs one cycle, with two younger instructions killed.
- Simultaneous events:
  - A freeze during LOAD_STALL pauses remaining.
  - A freeze while branchTaken is high delays the flush until memReady.
  - Branch together with load-use in RUN: the branch wins and no stall is taken.
- Counters and memTimeout update at the rising edge. Their outputs are registered.

## Test plan
- **Load-use, default stall.** LOAD_USE_STALL=1. Load to x5 in DEC_ALU; decode reads x5 on rs2 with decRs2Use=1. Required: one cycle of pcHold=ifDecHold=decAluBubble=1, then all 0. stallCycles=1.
- **Load-use, three-cycle stall, plus exclusions.** LOAD_USE_STALL=3 with the same stimulus. Required: exactly 3 consecutive stall cycles. FSM sequence RUN→LOAD_STALL→LOAD_STALL→RUN. A load to x0, or a match with decRs1Use=0, gives no stall.
- **Taken branch.** exValid=1, branchTaken=1. Required: ifDecFlush=decAluBubble=1 and pcHold=0 for one cycle. flushCount goes 0→1. A branch during a load-use match also takes no stall.
- **Freeze pauses a stall.** Enter LOAD_STALL with 2 cycles remaining. Hold memReq=1, memReady=0 for 4 cycles. Required: all four holds are 1 with no bubble for those 4 cycles, then 2 more stall cycles. stallCycles=7 in total (1 detection + 4 freeze + 2 stall).
- **Timeout.** MEM_TIMEOUT=4. Hold memReq=1, memReady=0 for 6 cycles. Required: memTimeout rises at the 4th edge and stays 1 after memReady=1. Only rst_n=0 clears it.
- **Asynchronous reset mid-stall.** Drop rst_n between clock edges while in LOAD_STALL. Required: outputs go to 0 immediately, and the FSM is RUN after release.
